// File: rtl/product_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// product_acc_pkg
// Shared definitions for the product accumulator.
//   state_t : FSM encoding (ACCUM collects products, HOLD presents a sum)
//   PROD_W  : width of the incoming multiplier product bus
//   cnt_w() : width of a counter able to hold 0..n
// ----------------------------------------------------------------------------
package product_acc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int PROD_W = 8;

    // Width of a counter that must represent every value from 0 to n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/acc_add_sat.sv
// ----------------------------------------------------------------------------
// acc_add_sat
// Combinational ACC_W+1-bit adder that folds one product into the
// accumulator.
//   acc      : current accumulator value (ACC_W bits)
//   prod     : unsigned product (PROD_W bits), zero-extended before the add
//   acc_next : accumulator value after the add (ACC_W bits)
//   carry    : the add carried out of ACC_W bits
// Build option PRODUCT_ACCUMULATOR_SAT_EN: when defined, a carry clamps
// acc_next to all ones; otherwise the sum wraps modulo 2^ACC_W.
// ----------------------------------------------------------------------------
module acc_add_sat
    import product_acc_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  acc_next,
    output logic              carry
);

    logic [ACC_W:0] sum_s;

    // Wide add, carry extraction and optional clamp.
    always_comb begin
        sum_s = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        carry = sum_s[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        // Once clamped, any later non-zero add carries again, so the value
        // stays pinned at the maximum for the rest of the group.
        if (carry) begin
            acc_next = {ACC_W{1'b1}};
        end else begin
            acc_next = sum_s[ACC_W-1:0];
        end
`else
        acc_next = sum_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// ----------------------------------------------------------------------------
// product_accumulator
// Sums groups of N_TERMS unsigned 8-bit products and presents each group sum
// on a held valid/ready output.
//   clk, reset_n        : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_prod is the product
//   out_valid/out_ready : output handshake, out_sum / out_ovf are the result
//   busy                : a group is partially accumulated or being held
// Parameters: N_TERMS (1..16) products per group, ACC_W (>= 8) result width.
// Build option PRODUCT_ACCUMULATOR_SAT_EN selects saturating instead of
// wrapping accumulation (see acc_add_sat).
// All outputs are registered.
// ----------------------------------------------------------------------------
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam int              CNT_W    = cnt_w(N_TERMS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [ACC_W-1:0]   out_sum_r;
    logic               out_ovf_r;
    logic               busy_r;

    logic               accept_s;
    logic               last_s;
    logic [ACC_W-1:0]   acc_next_s;
    logic               carry_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_ovf   = out_ovf_r;
    assign busy      = busy_r;

    // in_ready_r is only ever high in ACCUM, so it alone qualifies an accept.
    assign accept_s = in_valid & in_ready_r;
    assign last_s   = (cnt_r == LAST_CNT);

    acc_add_sat #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc      (acc_r),
        .prod     (in_prod),
        .acc_next (acc_next_s),
        .carry    (carry_s)
    );

    // Group FSM: accumulation, counting, handshakes and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ACCUM;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_sum_r   <= {ACC_W{1'b0}};
            out_ovf_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    out_valid_r <= 1'b0;
                    if (accept_s) begin
                        acc_r  <= acc_next_s;
                        cnt_r  <= cnt_r + CNT_ONE;
                        ovf_r  <= ovf_r | carry_s;
                        busy_r <= 1'b1;
                        if (last_s) begin
                            state_r     <= HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_sum_r   <= acc_next_s;
                            out_ovf_r   <= ovf_r | carry_s;
                        end else begin
                            in_ready_r <= 1'b1;
                        end
                    end else begin
                        // Also the path that raises in_ready after reset.
                        in_ready_r <= 1'b1;
                        busy_r     <= (cnt_r != {CNT_W{1'b0}});
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r     <= ACCUM;
                        acc_r       <= {ACC_W{1'b0}};
                        cnt_r       <= {CNT_W{1'b0}};
                        ovf_r       <= 1'b0;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ACCUM;
                    acc_r       <= {ACC_W{1'b0}};
                    cnt_r       <= {CNT_W{1'b0}};
                    ovf_r       <= 1'b0;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// ----------------------------------------------------------------------------
// tb_product_accumulator
// Directed bench for product_accumulator. Three instances:
//   dut  : N_TERMS=4, ACC_W=10 (main scenarios)
//   dut9 : N_TERMS=4, ACC_W=9  (overflow / saturation)
//   dut1 : N_TERMS=1, ACC_W=10 (single-term groups)
// ----------------------------------------------------------------------------
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_prod = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] out_sum;
    logic       out_ovf;
    logic       busy;

    logic       v9 = 1'b0;
    logic       rdy9;
    logic [7:0] p9 = 8'd0;
    logic       ov9;
    logic [8:0] sum9;
    logic       ovf9;
    logic       busy9;

    logic       v1 = 1'b0;
    logic       rdy1;
    logic [7:0] p1 = 8'd0;
    logic       ov1;
    logic [9:0] sum1;
    logic       ovf1;
    logic       busy1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    product_accumulator #(.N_TERMS(4), .ACC_W(10)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
    );

    product_accumulator #(.N_TERMS(4), .ACC_W(9)) dut9 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(v9), .in_ready(rdy9), .in_prod(p9),
        .out_valid(ov9), .out_ready(1'b1),
        .out_sum(sum9), .out_ovf(ovf9), .busy(busy9)
    );

    product_accumulator #(.N_TERMS(1), .ACC_W(10)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(v1), .in_ready(rdy1), .in_prod(p1),
        .out_valid(ov1), .out_ready(1'b1),
        .out_sum(sum1), .out_ovf(ovf1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one product to the main DUT and return #1 after it is accepted.
    task automatic push(input logic [7:0] p);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_prod  = p;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [6:0] gap_pat;
    logic [7:0] gap_vals [4];

    initial begin
        // Reset values while reset is held
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        check("rel_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        check("rel_in_ready_high", in_ready, 1);

        // Basic group 225+100+3+0
        out_ready = 1'b1;
        push(8'd225);
        check("g1_busy", busy, 1);
        check("g1_no_valid", out_valid, 0);
        push(8'd100);
        push(8'd3);
        push(8'd0);
        check("g1_valid", out_valid, 1);
        check("g1_sum", out_sum, 328);
        check("g1_ovf", out_ovf, 0);
        check("g1_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("g1_valid_drop", out_valid, 0);
        check("g1_ready_back", in_ready, 1);
        check("g1_busy_idle", busy, 0);

        // Four 255s with backpressure
        out_ready = 1'b0;
        push(8'd255);
        push(8'd255);
        push(8'd255);
        push(8'd255);
        check("bp_sum", out_sum, 1020);
        check("bp_ovf", out_ovf, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_prod  = 8'd77;
            @(posedge clk);
            #1;
            check("bp_hold_sum", out_sum, 1020);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", out_valid, 0);
        push(8'd1);
        push(8'd2);
        push(8'd3);
        push(8'd4);
        check("bp_next_sum", out_sum, 10);
        check("bp_next_valid", out_valid, 1);
        @(posedge clk);
        #1;

        // Gapped input: valid pattern 1,0,0,1,1,0,1
        gap_pat     = 7'b1011001;   // bit i = slot i
        gap_vals[0] = 8'd10;
        gap_vals[1] = 8'd20;
        gap_vals[2] = 8'd30;
        gap_vals[3] = 8'd40;
        begin
            int k;
            k = 0;
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                in_valid = gap_pat[i];
                if (gap_pat[i]) begin
                    in_prod = gap_vals[k];
                    k++;
                end else begin
                    in_prod = 8'd200;
                end
                @(posedge clk);
                #1;
                if (i == 5) check("gap_not_yet", out_valid, 0);
            end
        end
        in_valid = 1'b0;
        check("gap_valid", out_valid, 1);
        check("gap_sum", out_sum, 100);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-group
        push(8'd50);
        push(8'd60);
        check("ar_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_in_ready", in_ready, 0);
        check("ar_busy_clr", busy, 0);
        check("ar_out_valid", out_valid, 0);
        check("ar_out_sum", out_sum, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push(8'd1);
        push(8'd1);
        check("ar_no_partial", out_valid, 0);
        push(8'd1);
        push(8'd1);
        check("ar_valid", out_valid, 1);
        check("ar_sum", out_sum, 4);
        check("ar_ovf", out_ovf, 0);
        @(posedge clk);
        #1;

        // ACC_W=9 instance: four 255s overflow
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v9 = 1'b1;
            p9 = 8'd255;
            @(posedge clk);
            #1;
        end
        v9 = 1'b0;
        check("w9_valid", ov9, 1);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        check("w9_sum", sum9, 511);
`else
        check("w9_sum", sum9, 508);
`endif
        check("w9_ovf", ovf9, 1);

        // N_TERMS=1 instance: 7 then 9, in_ready 1,0,1,0
        @(negedge clk);
        check("n1_rdy_a", rdy1, 1);
        v1 = 1'b1;
        p1 = 8'd7;
        @(posedge clk);
        #1;
        check("n1_valid_a", ov1, 1);
        check("n1_sum_a", sum1, 7);
        @(negedge clk);
        check("n1_rdy_b", rdy1, 0);
        p1 = 8'd9;
        @(posedge clk);
        #1;
        check("n1_drop", ov1, 0);
        @(negedge clk);
        check("n1_rdy_c", rdy1, 1);
        @(posedge clk);
        #1;
        check("n1_valid_c", ov1, 1);
        check("n1_sum_c", sum1, 9);
        @(negedge clk);
        check("n1_rdy_d", rdy1, 0);
        v1 = 1'b0;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 5x3 combinational multiplier's 8-bit product bus.
- Accepts a stream of products over a valid/ready handshake and sums a fixed-length group of N_TERMS products into a wider accumulator.
- Presents each group sum on a held output with its own valid/ready handshake.
- Forms the accumulate half of the lab multiply-accumulate datapath.

Parameters:
- N_TERMS, 4: products summed per group; legal range 1..16.
- ACC_W, 10: accumulator and result width; must be at least 8.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_prod holds a product this cycle.
- in_ready  output  1  block accepts a product this cycle.
- in_prod  input  8  unsigned product from the multiplier.
- out_valid  output  1  out_sum holds a completed group sum.
- out_ready  input  1  consumer takes out_sum this cycle.
- out_sum  output  ACC_W  unsigned group sum.
- out_ovf  output  1  group sum exceeded 2^ACC_W-1.
- busy  output  1  a group is partially accumulated.

Behaviour:
- Reset: one clock, asynchronous active-low reset (reset_n), asserted asynchronously and released synchronously to clk. While reset is asserted:
  - state=ACCUM, accumulator=0, count=0, ovf=0.
  - in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
  - in_ready rises on the first clk edge after release.
- Input handshake: a product is accepted on a rising edge where in_valid&in_ready=1. in_prod is zero-extended to ACC_W+1 bits before the add.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: acc<=acc+in_prod, count<=count+1, and ovf is set sticky if the add carries out of ACC_W bits.
  - If the accept is the N_TERMS-th of the group, go to HOLD next cycle with out_sum=final acc.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_sum and out_ovf are held stable until out_ready=1.
  - On out_valid&out_ready: clear acc, count and ovf, and return to ACCUM. in_ready=1 the following cycle, so there is no same-cycle pass-through.
- Latency: out_valid rises exactly 1 cycle after the final accepted product.
- Throughput: N_TERMS+1 cycles per group minimum, assuming out_ready is held high.
- busy: 1 when count!=0 in ACCUM, or in HOLD; otherwise 0.
- Wrap (feature off): sum is modulo 2^ACC_W; out_ovf=1 if any add in the group carried out.
- N_TERMS=1: every accepted product goes straight to HOLD.
- in_valid held during HOLD: ignored and not consumed; the producer must hold in_prod.
- Reset mid-group or mid-HOLD: the partial sum is discarded and never emitted.
- Count width: $clog2(N_TERMS+1). Count never exceeds N_TERMS.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SAT_EN.
- Defined: on carry-out, acc clamps to 2^ACC_W-1 and stays there for the rest of the group. out_ovf still reports the event.
- Undefined: modulo wrap as described above.
- Handshake timing and port list are identical in both builds.

Decomposition:
- Package product_acc_pkg:
  - state typedef {ACCUM, HOLD}.
  - PROD_W=8.
  - Function cnt_w(n) returning $clog2(n+1).
- Sub-module acc_add_sat: combinational ACC_W+1-bit adder with a saturation mux under the macro. Outputs the next acc and the carry flag.
- FSM, counter and handshake logic stay in the top module.

Test Plan:
- Reset, then products 225,100,3,0 with out_ready=1 (N_TERMS=4, ACC_W=10) -> out_sum=328, out_ovf=0. out_valid rises 1 cycle after the 4th accept and stays high 1 cycle.
- Four products of 255, no macro -> sum 1020, out_ovf=0. Then four of 255 plus ACC_W=9 build -> out_sum=1020 mod 512=508, out_ovf=1. With PRODUCT_ACCUMULATOR_SAT_EN -> out_sum=511, out_ovf=1.
- Backpressure: out_ready=0 for 5 cycles after a group completes -> out_sum held constant, in_ready=0, and in_valid pulses are not consumed. Release -> next group starts from 0.
- Gapped input: in_valid toggling 1,0,0,1,1,0,1 with products 10,20,30,40 -> only the accepted beats count; out_sum=100.
- Async reset asserted mid-group after 2 products (50,60), then 4 products of 1 -> out_sum=4. The partial 110 is never output, and outputs go to reset values without waiting for clk.
- N_TERMS=1 build: products 7,9 back-to-back with out_ready=1 -> outputs 7 then 9, in_ready pattern 1,0,1,0.
